// File: rtl/psg_mixer_nch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : psg_mixer_nch                                                   |
// | Purpose  : Serial N-channel stereo PSG mixer. Each frame strobe captures   |
// |            all channel samples and pan codes, then walks the channels one  |
// |            per cycle, applying a 2-bit gain code to each. The frame result |
// |            (stereo, mono or mute) is averaged over 2^DECIM_LOG2 frames and |
// |            saturated to OUT_W bits.                                        |
// | Ports    : clk, reset_n     clock, asynchronous active-low reset           |
// |            ce               frame strobe, one input frame per pulse        |
// |            ch_in            packed samples, channel k at [k*IN_W +: IN_W]  |
// |            pan_l, pan_r     2-bit gain code per channel (off,1/4,1/2,1)    |
// |            mode             0 stereo, 1 mono, 2 mute, 3 stereo             |
// |            clear_flags      clears clip/overrun (a same-cycle set wins)    |
// |            out_l, out_r     averaged output samples, held between updates |
// |            out_valid        one-cycle pulse when out_l/out_r update        |
// |            clip, overrun    sticky saturation / dropped-frame flags        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module psg_mixer_nch #(
  parameter int CHANNELS   = 3,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 10,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic [CHANNELS*IN_W-1:0] ch_in,
  input  logic [2*CHANNELS-1:0]    pan_l,
  input  logic [2*CHANNELS-1:0]    pan_r,
  input  logic [1:0]               mode,
  input  logic                     clear_flags,
  output logic [OUT_W-1:0]         out_l,
  output logic [OUT_W-1:0]         out_r,
  output logic                     out_valid,
  output logic                     clip,
  output logic                     overrun
);

  // Frame sum width: one extra bit per doubling of channel count, and at
  // least one bit of headroom even for a single channel.
  localparam int CLOG = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int SW   = (CLOG > 0) ? (IN_W + CLOG) : (IN_W + 1);
  localparam int AW   = SW + DECIM_LOG2;
  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  // Comparison width wide enough for both the average and the output limit.
  localparam int CW   = ((SW > OUT_W) ? SW : OUT_W) + 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'((1 << DECIM_LOG2) - 1);
  localparam logic [CW-1:0]   MAX_OUT  = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [1:0]      MODE_MONO = 2'd1;
  localparam logic [1:0]      MODE_MUTE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;
  logic [CHANNELS*IN_W-1:0]   ch_sh_q, ch_sh_d;
  logic [2*CHANNELS-1:0]      pl_sh_q, pl_sh_d;
  logic [2*CHANNELS-1:0]      pr_sh_q, pr_sh_d;
  logic [1:0]                 mode_sh_q, mode_sh_d;
  logic [SW-1:0]              sum_l_q, sum_l_d;
  logic [SW-1:0]              sum_r_q, sum_r_d;
  logic [AW-1:0]              acc_l_q, acc_l_d;
  logic [AW-1:0]              acc_r_q, acc_r_d;
  logic [OUT_W-1:0]           out_l_q, out_l_d;
  logic [OUT_W-1:0]           out_r_q, out_r_d;
  logic                       valid_q, valid_d;
  logic                       clip_q, clip_d;
  logic                       ovr_q, ovr_d;

  // Gain code: 0 off, 1 quarter, 2 half, 3 full; result truncated to IN_W.
  function automatic logic [IN_W-1:0] apply_gain(input logic [1:0] code,
                                                 input logic [IN_W-1:0] x);
    logic [IN_W-1:0] g;
    case (code)
      2'd0:    g = '0;
      2'd1:    g = x >> 2;
      2'd2:    g = x >> 1;
      default: g = x;
    endcase
    return g;
  endfunction

  // Current channel, selected from the shadow copy taken at the frame strobe.
  logic [IN_W-1:0] cur_smp;
  logic [1:0]      cur_pl;
  logic [1:0]      cur_pr;

  assign cur_smp = ch_sh_q[int'(idx_q)*IN_W +: IN_W];
  assign cur_pl  = pl_sh_q[int'(idx_q)*2 +: 2];
  assign cur_pr  = pr_sh_q[int'(idx_q)*2 +: 2];

  // Frame result after mode, window sum including this frame, and the
  // averaged/saturated values used when the window closes.
  logic [SW:0]      mono_sum;
  logic [SW-1:0]    fin_l, fin_r;
  logic [AW-1:0]    acc_sum_l, acc_sum_r;
  logic [CW-1:0]    avg_l, avg_r;
  logic             sat_l, sat_r;
  logic [OUT_W-1:0] res_l, res_r;

  always_comb begin
    mono_sum = {1'b0, sum_l_q} + {1'b0, sum_r_q};
    fin_l    = sum_l_q;
    fin_r    = sum_r_q;
    if (mode_sh_q == MODE_MONO) begin
      fin_l = SW'(mono_sum >> 1);
      fin_r = SW'(mono_sum >> 1);
    end else if (mode_sh_q == MODE_MUTE) begin
      fin_l = '0;
      fin_r = '0;
    end
    acc_sum_l = acc_l_q + AW'(fin_l);
    acc_sum_r = acc_r_q + AW'(fin_r);
    avg_l     = CW'(SW'(acc_sum_l >> DECIM_LOG2));
    avg_r     = CW'(SW'(acc_sum_r >> DECIM_LOG2));
    sat_l     = (avg_l > MAX_OUT);
    sat_r     = (avg_r > MAX_OUT);
    res_l     = sat_l ? {OUT_W{1'b1}} : avg_l[OUT_W-1:0];
    res_r     = sat_r ? {OUT_W{1'b1}} : avg_r[OUT_W-1:0];
  end

  // Next-state logic.
  logic clip_set;
  logic ovr_set;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ch_sh_d   = ch_sh_q;
    pl_sh_d   = pl_sh_q;
    pr_sh_d   = pr_sh_q;
    mode_sh_d = mode_sh_q;
    sum_l_d   = sum_l_q;
    sum_r_d   = sum_r_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    valid_d   = 1'b0;
    clip_set  = 1'b0;
    // Any strobe outside IDLE (including the FINISH cycle) is a dropped frame.
    ovr_set   = ce && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ce) begin
          ch_sh_d   = ch_in;
          pl_sh_d   = pan_l;
          pr_sh_d   = pan_r;
          mode_sh_d = mode;
          sum_l_d   = '0;
          sum_r_d   = '0;
          idx_d     = '0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        sum_l_d = sum_l_q + SW'(apply_gain(cur_pl, cur_smp));
        sum_r_d = sum_r_q + SW'(apply_gain(cur_pr, cur_smp));
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FINISH: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          acc_l_d  = '0;
          acc_r_d  = '0;
          out_l_d  = res_l;
          out_r_d  = res_r;
          valid_d  = 1'b1;
          clip_set = sat_l | sat_r;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          acc_l_d = acc_sum_l;
          acc_r_d = acc_sum_r;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set has priority over the clear request.
    clip_d = (clip_q & ~clear_flags) | clip_set;
    ovr_d  = (ovr_q  & ~clear_flags) | ovr_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      ch_sh_q   <= '0;
      pl_sh_q   <= '0;
      pr_sh_q   <= '0;
      mode_sh_q <= '0;
      sum_l_q   <= '0;
      sum_r_q   <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ch_sh_q   <= ch_sh_d;
      pl_sh_q   <= pl_sh_d;
      pr_sh_q   <= pr_sh_d;
      mode_sh_q <= mode_sh_d;
      sum_l_q   <= sum_l_d;
      sum_r_q   <= sum_r_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = valid_q;
  assign clip      = clip_q;
  assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_psg_mixer_nch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_psg_mixer_nch                                                |
// | Purpose  : Self-checking bench for psg_mixer_nch. Two instances share the  |
// |            same stimulus: OUT_W=10 (no saturation possible with 3x8-bit)   |
// |            and OUT_W=8 (saturates). Expected pulses come from a frame-level |
// |            arithmetic model fed by the frame driver.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_psg_mixer_nch;

  localparam int C    = 3;
  localparam int IN_W = 8;
  localparam int D    = 2;
  localparam int LAT  = C + 2;
  localparam int NFR  = 1 << D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        clear_flags;
  logic [23:0] ch_in;
  logic [5:0]  pan_l;
  logic [5:0]  pan_r;
  logic [1:0]  mode;

  logic [9:0]  out_l0, out_r0;
  logic        v0, clip0, ovr0;
  logic [7:0]  out_l1, out_r1;
  logic        v1, clip1, ovr1;

  psg_mixer_nch #(.CHANNELS(C), .IN_W(IN_W), .OUT_W(10), .DECIM_LOG2(D)) u_dut10 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ch_in(ch_in), .pan_l(pan_l),
    .pan_r(pan_r), .mode(mode), .clear_flags(clear_flags), .out_l(out_l0),
    .out_r(out_r0), .out_valid(v0), .clip(clip0), .overrun(ovr0)
  );

  psg_mixer_nch #(.CHANNELS(C), .IN_W(IN_W), .OUT_W(8), .DECIM_LOG2(D)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ch_in(ch_in), .pan_l(pan_l),
    .pan_r(pan_r), .mode(mode), .clear_flags(clear_flags), .out_l(out_l1),
    .out_r(out_r1), .out_valid(v1), .clip(clip1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int l;
    int r;
  } ev_t;

  ev_t obs0[$], obs1[$], exp0[$], exp1[$];
  int  n_pass, n_total;
  int  hold_err = 0;

  // Monitor: records every out_valid pulse and counts output changes that
  // happen without a pulse.
  logic [9:0] pl0 = '0, pr0 = '0;
  logic [7:0] pl1 = '0, pr1 = '0;
  logic       prev_rst = 1'b0;
  always @(negedge clk) begin
    if (reset_n && prev_rst) begin
      if (v0) obs0.push_back('{cyc, int'(out_l0), int'(out_r0)});
      else if (out_l0 !== pl0 || out_r0 !== pr0) hold_err <= hold_err + 1;
      if (v1) obs1.push_back('{cyc, int'(out_l1), int'(out_r1)});
      else if (out_l1 !== pl1 || out_r1 !== pr1) hold_err <= hold_err + 1;
    end
    pl0 <= out_l0; pr0 <= out_r0; pl1 <= out_l1; pr1 <= out_r1;
    prev_rst <= reset_n;
  end

  // Reference model state: frame-level window sums and acceptance timing.
  int m_sl, m_sr, m_fr, m_last;
  bit m_clip0, m_clip1, m_ovr;

  task automatic model_reset;
    m_sl = 0; m_sr = 0; m_fr = 0; m_last = -1000;
    m_clip0 = 0; m_clip1 = 0; m_ovr = 0;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  function automatic int gain(input int code, input int x);
    case (code)
      0:       return 0;
      1:       return x / 4;
      2:       return x / 2;
      default: return x;
    endcase
  endfunction

  task automatic junk;
    ch_in = 24'($urandom);
    pan_l = 6'($urandom);
    pan_r = 6'($urandom);
    mode  = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      junk();
    end
  endtask

  // Drive one ce pulse carrying a frame (call at a negedge, returns at the
  // next negedge) and let the model decide whether it is accepted.
  task automatic send_frame(input logic [23:0] ch, input logic [5:0] pl,
                            input logic [5:0] pr, input logic [1:0] md);
    int p;
    int fl, fr, al, ar, lsum, rsum;
    p = cyc;
    ch_in = ch; pan_l = pl; pan_r = pr; mode = md; ce = 1'b1;
    if (p - m_last < LAT) begin
      m_ovr = 1;
    end else begin
      m_last = p;
      lsum = 0; rsum = 0;
      for (int k = 0; k < C; k++) begin
        lsum += gain(int'(pl[2*k +: 2]), int'(ch[k*IN_W +: IN_W]));
        rsum += gain(int'(pr[2*k +: 2]), int'(ch[k*IN_W +: IN_W]));
      end
      if (md == 2'd1) begin
        fl = (lsum + rsum) / 2; fr = fl;
      end else if (md == 2'd2) begin
        fl = 0; fr = 0;
      end else begin
        fl = lsum; fr = rsum;
      end
      m_sl += fl; m_sr += fr; m_fr++;
      if (m_fr == NFR) begin
        al = m_sl / NFR; ar = m_sr / NFR;
        exp0.push_back('{p + LAT, (al > 1023) ? 1023 : al, (ar > 1023) ? 1023 : ar});
        exp1.push_back('{p + LAT, (al > 255) ? 255 : al, (ar > 255) ? 255 : ar});
        if (al > 1023 || ar > 1023) m_clip0 = 1;
        if (al > 255 || ar > 255) m_clip1 = 1;
        m_sl = 0; m_sr = 0; m_fr = 0;
      end
    end
    @(negedge clk);
    ce = 1'b0;
    junk();
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; ce = 1'b0; clear_flags = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_l0, out_r0, v0, clip0, ovr0} !== '0) $display("FAIL reset_dut10: got %0d/%0d v=%0d clip=%0d ovr=%0d required all 0", out_l0, out_r0, v0, clip0, ovr0);
    else n_pass++;
    n_total++;
    if ({out_l1, out_r1, v1, clip1, ovr1} !== '0) $display("FAIL reset_dut8: got %0d/%0d v=%0d clip=%0d ovr=%0d required all 0", out_l1, out_r1, v1, clip1, ovr1);
    else n_pass++;
    reset_n = 1'b1;
    model_reset();
    idle(6);
    n_total++;
    if (obs0.size() != 0 || obs1.size() != 0) $display("FAIL reset_no_pulse: got %0d pulses required 0", obs0.size() + obs1.size());
    else n_pass++;
    n_total++;
    if ({out_l0, out_r0, clip0, ovr0, out_l1, out_r1, clip1, ovr1} !== '0) $display("FAIL reset_idle_outputs: outputs changed without ce");
    else n_pass++;
  endtask

  task automatic test_modes;
    int el[3];
    int er[3];
    el = '{125, 87, 0};
    er = '{50, 87, 0};
    for (int md = 0; md < 3; md++) begin
      int h0;
      do_reset();
      h0 = hold_err;
      repeat (8) begin
        send_frame({8'd50, 8'd100, 8'd200}, 6'b00_01_10, 6'b10_01_00, 2'(md));
        idle(9);
      end
      for (int d = 0; d < 2; d++) begin
        ev_t o[$];
        ev_t e[$];
        if (d == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
        n_total++;
        if (o.size() != 2) $display("FAIL mode%0d_dut%0d_count: got %0d required 2", md, d, o.size());
        else n_pass++;
        for (int i = 0; i < o.size() && i < e.size(); i++) begin
          n_total++;
          if (o[i].c !== e[i].c || o[i].l !== el[md] || o[i].r !== er[md]) $display("FAIL mode%0d_dut%0d_pulse%0d: got cyc=%0d l=%0d r=%0d required cyc=%0d l=%0d r=%0d", md, d, i, o[i].c, o[i].l, o[i].r, e[i].c, el[md], er[md]);
          else n_pass++;
        end
      end
      n_total++;
      if (clip0 !== 1'b0 || ovr0 !== 1'b0 || clip1 !== 1'b0) $display("FAIL mode%0d_flags: got clip=%0d ovr=%0d clip8=%0d required 0", md, clip0, ovr0, clip1);
      else n_pass++;
      n_total++;
      if (hold_err != h0) $display("FAIL mode%0d_hold: got %0d changes without out_valid required 0", md, hold_err - h0);
      else n_pass++;
    end
  endtask

  task automatic test_saturation;
    do_reset();
    repeat (4) begin
      send_frame(24'hFFFFFF, 6'h3F, 6'h3F, 2'd0);
      idle(LAT + 2);
    end
    n_total++;
    if (obs1.size() != 1 || obs1[0].l != 255 || obs1[0].r != 255) $display("FAIL sat_dut8_value: got n=%0d l=%0d r=%0d required n=1 l=255 r=255", obs1.size(), out_l1, out_r1);
    else n_pass++;
    n_total++;
    if (obs0.size() != 1 || obs0[0].l != 765 || obs0[0].r != 765) $display("FAIL sat_dut10_value: got n=%0d l=%0d r=%0d required n=1 l=765 r=765", obs0.size(), out_l0, out_r0);
    else n_pass++;
    n_total++;
    if (clip1 !== 1'b1 || clip0 !== 1'b0) $display("FAIL sat_clip: got clip8=%0d clip10=%0d required 1 and 0", clip1, clip0);
    else n_pass++;
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    n_total++;
    if (clip1 !== 1'b0) $display("FAIL sat_clear: got clip=%0d required 0", clip1);
    else n_pass++;
    // Clear asserted in the FINISH cycle of a saturating window: set wins.
    repeat (3) begin
      send_frame(24'hFFFFFF, 6'h3F, 6'h3F, 2'd0);
      idle(LAT - 1);
    end
    send_frame(24'hFFFFFF, 6'h3F, 6'h3F, 2'd0);
    idle(2);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    n_total++;
    if (clip1 !== 1'b1 || v1 !== 1'b1) $display("FAIL sat_set_wins: got clip=%0d valid=%0d required 1 and 1", clip1, v1);
    else n_pass++;
    // Dropped ce in the same cycle as clear: overrun stays set.
    idle(3);
    send_frame(24'h010203, 6'h3F, 6'h3F, 2'd0);
    idle(1);
    clear_flags = 1'b1;
    send_frame(24'h040506, 6'h3F, 6'h3F, 2'd0);
    clear_flags = 1'b0;
    n_total++;
    if (ovr1 !== 1'b1 || ovr0 !== 1'b1) $display("FAIL ovr_set_wins: got ovr=%0d/%0d required 1", ovr0, ovr1);
    else n_pass++;
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    n_total++;
    if (ovr0 !== 1'b0) $display("FAIL ovr_clear: got ovr=%0d required 0", ovr0);
    else n_pass++;
    idle(LAT + 2);
  endtask

  task automatic test_overrun;
    do_reset();
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // accepted
    idle(1);
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // +2: dropped
    idle(1);
    n_total++;
    if (ovr0 !== 1'b1 || ovr1 !== 1'b1) $display("FAIL ovr_set: got ovr=%0d/%0d required 1", ovr0, ovr1);
    else n_pass++;
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // +4: dropped (FINISH)
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // +5: accepted
    idle(LAT - 1);
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
    idle(LAT + 2);
    n_total++;
    if (obs0.size() != 0) $display("FAIL ovr_early_pulse: got %0d pulses after 3 accepted frames required 0", obs0.size());
    else n_pass++;
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
    idle(LAT + 2);
    for (int d = 0; d < 2; d++) begin
      ev_t o[$];
      ev_t e[$];
      if (d == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
      n_total++;
      if (o.size() != 1 || e.size() != 1) $display("FAIL ovr_dut%0d_count: got %0d required 1", d, o.size());
      else n_pass++;
      for (int i = 0; i < o.size() && i < e.size(); i++) begin
        n_total++;
        if (o[i].c !== e[i].c || o[i].l !== e[i].l || o[i].r !== e[i].r) $display("FAIL ovr_dut%0d_pulse%0d: got cyc=%0d l=%0d r=%0d required cyc=%0d l=%0d r=%0d", d, i, o[i].c, o[i].l, o[i].r, e[i].c, e[i].l, e[i].r);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_frame(24'($urandom) | 24'h808080, 6'h3F, 6'h3F, 2'd0);
    idle(1);
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // dropped
    idle(2);
    repeat (3) begin
      send_frame(24'($urandom) | 24'h808080, 6'h3F, 6'h3F, 2'd0);
      idle(LAT - 1);
    end
    idle(3);
    n_total++;
    if (obs0.size() != 1 || exp0.size() != 1 || obs0[0].l !== exp0[0].l || obs0[0].c !== exp0[0].c) $display("FAIL rmid_first_window: got n=%0d l=%0d required n=1 as modelled", obs0.size(), out_l0);
    else n_pass++;
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
    idle(LAT - 1);
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
    idle(LAT - 1);
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);   // 3rd frame
    @(negedge clk);                                                // ACCUM
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({out_l0, out_r0, v0, clip0, ovr0} !== '0) $display("FAIL rmid_dut10_zero: got %0d/%0d v=%0d clip=%0d ovr=%0d required all 0", out_l0, out_r0, v0, clip0, ovr0);
    else n_pass++;
    n_total++;
    if ({out_l1, out_r1, v1, clip1, ovr1} !== '0) $display("FAIL rmid_dut8_zero: got %0d/%0d v=%0d clip=%0d ovr=%0d required all 0", out_l1, out_r1, v1, clip1, ovr1);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(1);
    repeat (3) begin
      send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
      idle(LAT - 1);
    end
    idle(LAT);
    n_total++;
    if (obs0.size() != 0 || obs1.size() != 0) $display("FAIL rmid_no_early_pulse: got %0d pulses required 0", obs0.size() + obs1.size());
    else n_pass++;
    send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'd0);
    idle(LAT + 2);
    for (int d = 0; d < 2; d++) begin
      ev_t o[$];
      ev_t e[$];
      if (d == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
      n_total++;
      if (o.size() != 1 || e.size() != 1) $display("FAIL rmid_dut%0d_count: got %0d required 1", d, o.size());
      else n_pass++;
      for (int i = 0; i < o.size() && i < e.size(); i++) begin
        n_total++;
        if (o[i].c !== e[i].c || o[i].l !== e[i].l || o[i].r !== e[i].r) $display("FAIL rmid_dut%0d_pulse%0d: got cyc=%0d l=%0d r=%0d required cyc=%0d l=%0d r=%0d", d, i, o[i].c, o[i].l, o[i].r, e[i].c, e[i].l, e[i].r);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random;
    int h0;
    do_reset();
    h0 = hold_err;
    for (int n = 0; n < 60; n++) begin
      send_frame(24'($urandom), 6'($urandom), 6'($urandom), 2'($urandom_range(0, 3)));
      idle($urandom_range(1, 7));
    end
    idle(LAT + 3);
    for (int d = 0; d < 2; d++) begin
      ev_t o[$];
      ev_t e[$];
      if (d == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
      n_total++;
      if (o.size() != e.size()) $display("FAIL rand_dut%0d_count: got %0d required %0d", d, o.size(), e.size());
      else n_pass++;
      for (int i = 0; i < o.size() && i < e.size(); i++) begin
        n_total++;
        if (o[i].c !== e[i].c || o[i].l !== e[i].l || o[i].r !== e[i].r) $display("FAIL rand_dut%0d_pulse%0d: got cyc=%0d l=%0d r=%0d required cyc=%0d l=%0d r=%0d", d, i, o[i].c, o[i].l, o[i].r, e[i].c, e[i].l, e[i].r);
        else n_pass++;
      end
    end
    n_total++;
    if (ovr0 !== m_ovr || ovr1 !== m_ovr) $display("FAIL rand_overrun: got %0d/%0d required %0d", ovr0, ovr1, m_ovr);
    else n_pass++;
    n_total++;
    if (clip0 !== m_clip0 || clip1 !== m_clip1) $display("FAIL rand_clip: got %0d/%0d required %0d/%0d", clip0, clip1, m_clip0, m_clip1);
    else n_pass++;
    n_total++;
    if (hold_err != h0) $display("FAIL rand_hold: got %0d changes without out_valid required 0", hold_err - h0);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    ce = 1'b0;
    clear_flags = 1'b0;
    junk();
    model_reset();
    test_reset();
    test_modes();
    test_saturation();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psg_mixer_nch.md
Name: psg_mixer_nch

Overview:
- Parametrised successor to the fixed 3-channel PSG audio mix in the motherboard: a serial, N-channel stereo mixer with per-channel pan/gain codes, a mono/mute mode, decimating averaging and saturation.
- Sits between one or more YM2149 instances (main plus expansion PSG) and the audio output path.
- Replaces the combinational channel-shift sum with a sequenced multiply-accumulate, averaged over 2^DECIM_LOG2 sample frames.

Parameters:
- CHANNELS, 3: number of input channels (1..8).
- IN_W, 8: width of each unsigned channel sample.
- OUT_W, 10: width of each output sample.
- DECIM_LOG2, 2: frames averaged per output = 2^DECIM_LOG2 (0..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  frame strobe (PSG clock enable); one input frame per pulse.
- ch_in  in  CHANNELS*IN_W  packed channel samples; channel k at bits [k*IN_W +: IN_W].
- pan_l  in  2*CHANNELS  left gain code per channel: 0 off, 1 quarter (>>2), 2 half (>>1), 3 full.
- pan_r  in  2*CHANNELS  right gain codes, same encoding.
- mode  in  2  0 stereo, 1 mono, 2 mute, 3 reserved (behaves as stereo).
- clear_flags  in  1  synchronous clear of the sticky flags.
- out_l  out  OUT_W  left output sample.
- out_r  out  OUT_W  right output sample.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- clip  out  1  sticky: an output saturated.
- overrun  out  1  sticky: a ce arrived while the mixer was busy.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, accumulators, frame counter and channel index all 0.
- SW = IN_W + clog2(CHANNELS) (minimum IN_W+1); window accumulators are SW+DECIM_LOG2 bits.
- IDLE:
  - On ce, capture ch_in, pan_l, pan_r and mode into shadow registers.
  - Clear the frame sums L/R; index=0; go to ACCUM.
- ACCUM, one channel per cycle for CHANNELS cycles:
  - L += gain(pan_l[idx], ch[idx]); R += gain(pan_r[idx], ch[idx]).
  - Each product is truncated per channel before it is added.
  - After idx=CHANNELS-1, go to FINISH.
- FINISH, one cycle:
  - Apply the mode. Mono: both sides get (L+R)>>1, truncated. Mute: both 0.
  - Add the results to the window accumulators; increment the frame counter.
  - If the counter wraps from 2^DECIM_LOG2-1 to 0:
    - avg = acc >> DECIM_LOG2.
    - Each side: out = avg if avg <= 2^OUT_W-1, else all ones, and set clip.
    - Register out_l/out_r, pulse out_valid the next cycle, clear the accumulators.
  - Return to IDLE.
- Latency: out_valid is high exactly CHANNELS+2 cycles after the ce of the window's last frame; out_l/out_r change only in that cycle.
- Minimum ce spacing is CHANNELS+2 cycles. A ce seen in ACCUM or FINISH:
  - the frame is dropped and overrun is set;
  - the current frame, the frame counter and the captured inputs are unaffected.
- A ce in the same cycle as the FINISH→IDLE transition counts as busy (dropped).
- clear_flags clears clip and overrun; a set condition in the same cycle wins over the clear.
- Input and mode changes take effect only at the next ce capture.
- Mute still produces out_valid pulses, with out 0.
- out_l/out_r hold their value between pulses.
- Reset mid-frame aborts immediately: no out_valid pulse, and the partial window is discarded.

Test Plan:
- Stereo mapping with CHANNELS=3, IN_W=8, OUT_W=10, DECIM_LOG2=2:
  - Stimulus: A=200, B=100, C=50; pan_l A=2, B=1, C=0; pan_r A=0, B=1, C=2; 8 ce pulses spaced 10 cycles.
  - Required: out_l=125, out_r=50; exactly 2 out_valid pulses, each 5 cycles after the 4th and 8th ce; clip=0.
- Mono: same inputs with mode=1 -> out_l=out_r=87.
- Mute: mode=2 -> out_valid still pulses every 4 ce; out_l=out_r=0.
- Saturation with OUT_W=8:
  - Stimulus: all channels 255, all codes 3.
  - Required: sum 765 -> out_l=out_r=255, clip=1.
  - clear_flags -> clip=0 unless saturation recurs in the same cycle.
- Overrun:
  - Stimulus: two ce pulses 2 cycles apart.
  - Required: the second is dropped, overrun=1, and the window still needs 4 accepted frames before out_valid.
  - Boundary: a ce exactly CHANNELS+2 cycles after the previous one is accepted.
- Reset mid-ACCUM: assert reset_n=0 for 1 cycle during the 3rd frame.
  - All outputs and flags go to 0 immediately.
  - The next out_valid comes only after 4 further accepted frames.
